// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch unit
// Purpose: R-type opcode, default memory size, instruction field layout,
//          fetch FSM encoding and an opcode extraction helper.
// Ports:   none (package).
package instr_fetch_pkg;

  localparam logic [5:0] Rtype_op = 6'b000100;

  localparam int INSTR_MEM_SIZE_DEFAULT = 128;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  // Field layout: opcode [31:26], Rs [25:21], Rt [20:16], Rd [15:11],
  // Shamt [10:6], Funct [5:0].
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_fields_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [5:0] get_opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory bus plus decoder handshake
// Purpose: bundles the fetch-side memory bus and the decoder valid/ready stream.
// Signals: InstrAddr/Instr (memory), InstrOut/InstrPC/InstrValid/InstrReady (decoder).
// Modports: master = fetch unit, slave = memory + decoder side.
interface instr_fetch_if;
  logic [31:0] InstrAddr;
  logic [31:0] Instr;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;

  modport master (
    output InstrAddr,
    input  Instr,
    output InstrOut,
    output InstrPC,
    output InstrValid,
    input  InstrReady
  );

  modport slave (
    input  InstrAddr,
    output Instr,
    input  InstrOut,
    input  InstrPC,
    input  InstrValid,
    output InstrReady
  );
endinterface

// File: rtl/if_queue.sv
// rtl/if_queue.sv - prefetch FIFO of {PC, Instr} entries
// Purpose: synchronous FIFO, DEPTH entries (power of two, >= 2), 64-bit wide.
// Ports: clk, rst_n (async active-low), push, pop, flush, wdata[63:0],
//        rdata[63:0] (head entry, read combinationally), count.
module if_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [63:0]                wdata,
  output logic [63:0]                rdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  assign rdata = mem[head];

  // Storage is reset too so the head word reads as zero right after reset.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with prefetch queue and redirect
// Purpose: drives InstrAddr from the PC, queues fetched words, presents them in
//          program order, handles redirects and halts at the end of memory.
// Ports: clk, rst_n (async active-low); bus (instr_fetch_if.master);
//        Redirect, RedirectAddr[31:0]; Halted, AddrErr (sticky);
//        IllegalOp when IF_RTYPE_CHECK_EN is defined.
// Macro: IF_RTYPE_CHECK_EN adds the IllegalOp output.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEFAULT,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus,
  input  logic          Redirect,
  input  logic [31:0]   RedirectAddr,
  output logic          Halted,
  output logic          AddrErr
`ifdef IF_RTYPE_CHECK_EN
  ,
  output logic          IllegalOp
`endif
);
  localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [31:0] MEM_END = 32'(INSTR_MEM_SIZE);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [CW-1:0] count;
  logic [63:0]  head_entry;
  logic         push;
  logic         pop;
  logic         redirect_bad;

  assign bus.InstrAddr  = pc;
  assign bus.InstrValid = (count != '0);
  assign bus.InstrPC    = head_entry[63:32];
  assign bus.InstrOut   = head_entry[31:0];
  assign Halted         = (state == HALT);

  // Redirect wins over both queue ports; a head offered in that cycle is dropped.
  assign pop  = bus.InstrValid && bus.InstrReady && !Redirect;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push = (state == RUN) && ((count < CW'(QUEUE_DEPTH)) || pop) && !Redirect;

  assign redirect_bad = (RedirectAddr[1:0] != 2'b00) || (RedirectAddr >= MEM_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pc      <= '0;
      AddrErr <= 1'b0;
    end else if (Redirect) begin
      if (redirect_bad) begin
        state   <= HALT;
        AddrErr <= 1'b1;
      end else begin
        pc    <= RedirectAddr;
        state <= RUN;
      end
    end else if (push) begin
      // The last word is fetched but PC stays on it so InstrAddr stays in range.
      if (pc + 32'd4 == MEM_END) begin
        state <= HALT;
      end else begin
        pc <= pc + 32'd4;
      end
    end
  end

  if_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (Redirect),
    .wdata ({pc, bus.Instr}),
    .rdata (head_entry),
    .count (count)
  );

`ifdef IF_RTYPE_CHECK_EN
  assign IllegalOp = bus.InstrValid && (get_opcode(bus.InstrOut) != Rtype_op);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int MEM_SIZE = 128;

  logic        clk;
  logic        rst_n;
  logic        Redirect;
  logic [31:0] RedirectAddr;
  logic        Halted;
  logic        AddrErr;
`ifdef IF_RTYPE_CHECK_EN
  logic        IllegalOp;
`endif

  instr_fetch_if bus ();

  logic [31:0] imem [MEM_SIZE/4];
  logic [63:0] sb [$];

  int n_chk;
  int n_fail;

  instr_fetch #(
    .INSTR_MEM_SIZE(MEM_SIZE),
    .QUEUE_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .Halted       (Halted),
    .AddrErr      (AddrErr)
`ifdef IF_RTYPE_CHECK_EN
    ,
    .IllegalOp    (IllegalOp)
`endif
  );

  assign bus.Instr = (bus.InstrAddr < MEM_SIZE) ? imem[bus.InstrAddr[6:2]] : 32'hDEADBEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after reset or a legal redirect to A, the decoder must see
  // A, A+4, ... up to the last word, in order, each with its memory contents.
  task automatic sb_restart(input logic [31:0] a);
    sb.delete();
    for (int p = int'(a); p < MEM_SIZE; p += 4) begin
      sb.push_back({32'(p), imem[p/4]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    Redirect     = 1'b1;
    RedirectAddr = a;
    if (a[1:0] == 2'b00 && a < MEM_SIZE) sb_restart(a);
    else sb.delete();
    tick();
    Redirect = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},   bus.InstrAddr, 32'h0);
    chk({tag, "_out"},    bus.InstrOut, 32'h0);
    chk({tag, "_pc"},     bus.InstrPC, 32'h0);
    chk({tag, "_valid"},  32'(bus.InstrValid), 32'h0);
    chk({tag, "_halted"}, 32'(Halted), 32'h0);
    chk({tag, "_addrerr"}, 32'(AddrErr), 32'h0);
  endtask

  // Monitor: every accepted head must be the next word the model predicts.
  always @(negedge clk) begin
    if (rst_n && bus.InstrValid) begin
`ifdef IF_RTYPE_CHECK_EN
      chk("illegal_op", 32'(IllegalOp), 32'(bus.InstrOut[31:26] != 6'b000100));
`endif
      if (bus.InstrReady && !Redirect) begin
        if (sb.size() == 0) begin
          chk("extra_delivery_pc", bus.InstrPC, 32'hFFFFFFFF);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("deliv_pc", bus.InstrPC, e[63:32]);
          chk("deliv_instr", bus.InstrOut, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc_before;
    int          r;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < MEM_SIZE/4; i++) begin
      imem[i] = $urandom;
      if (i % 3 == 0) imem[i][31:26] = 6'b000100;
    end
    imem[0] = 32'h114B600B;

    rst_n          = 1'b0;
    Redirect       = 1'b0;
    RedirectAddr   = 32'h0;
    bus.InstrReady = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");

    // Streaming from reset at one word per cycle.
    bus.InstrReady = 1'b1;
    sb_restart(32'h0);
    rst_n = 1'b1;
    chk("addr_c0", bus.InstrAddr, 32'h0);
    tick();
    chk("first_valid", 32'(bus.InstrValid), 32'h1);
    chk("first_instr", bus.InstrOut, 32'h114B600B);
    chk("first_pc", bus.InstrPC, 32'h0);
    chk("addr_c1", bus.InstrAddr, 32'h4);
    tick();
    chk("addr_c2", bus.InstrAddr, 32'h8);
    chk("stream_valid2", 32'(bus.InstrValid), 32'h1);
    tick();
    chk("addr_c3", bus.InstrAddr, 32'hC);
    chk("stream_valid3", 32'(bus.InstrValid), 32'h1);

    // Stall: queue fills to 4, PC stops at 16, then drains back-to-back.
    bus.InstrReady = 1'b0;
    do_redirect(32'h0);
    chk("redir_flush_valid", 32'(bus.InstrValid), 32'h0);
    repeat (10) tick();
    chk("stall_addr", bus.InstrAddr, 32'd16);
    chk("stall_head_pc", bus.InstrPC, 32'h0);
    bus.InstrReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", 32'(bus.InstrValid), 32'h1);
      chk("drain_pc", bus.InstrPC, 32'(4*k));
      tick();
    end

    // Run to the end of memory.
    for (int i = 0; i < 200 && !Halted; i++) tick();
    chk("halt_reached", 32'(Halted), 32'h1);
    chk("halt_addr", bus.InstrAddr, 32'd124);
    for (int i = 0; i < 20 && bus.InstrValid; i++) tick();
    chk("halt_drained", 32'(bus.InstrValid), 32'h0);
    chk("halt_addr_hold", bus.InstrAddr, 32'd124);
    chk("halt_sb_empty", 32'(sb.size()), 32'h0);

    // Redirect with 3 entries queued discards them.
    bus.InstrReady = 1'b0;
    do_redirect(32'h0);
    chk("halt_cleared", 32'(Halted), 32'h0);
    repeat (3) tick();
    bus.InstrReady = 1'b1;
    do_redirect(32'h8);
    chk("redir8_flush", 32'(bus.InstrValid), 32'h0);
    tick();
    chk("redir8_valid", 32'(bus.InstrValid), 32'h1);
    chk("redir8_pc", bus.InstrPC, 32'h8);

    // Misaligned redirect.
    pc_before = bus.InstrAddr;
    do_redirect(32'h6);
    chk("mis_addrerr", 32'(AddrErr), 32'h1);
    chk("mis_halted", 32'(Halted), 32'h1);
    chk("mis_pc", bus.InstrAddr, pc_before);
    chk("mis_valid", 32'(bus.InstrValid), 32'h0);
    repeat (3) tick();
    chk("mis_pc_hold", bus.InstrAddr, pc_before);
    do_redirect(32'h0);
    tick();
    chk("resume_valid", 32'(bus.InstrValid), 32'h1);
    chk("resume_pc", bus.InstrPC, 32'h0);
    chk("resume_addrerr", 32'(AddrErr), 32'h1);
    chk("resume_halted", 32'(Halted), 32'h0);

    // Asynchronous reset with a full queue.
    bus.InstrReady = 1'b0;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    tick();
    rst_n = 1'b1;
    sb_restart(32'h0);
    bus.InstrReady = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.InstrValid), 32'h1);
    chk("post_rst_pc", bus.InstrPC, 32'h0);

    // Out-of-range redirect.
    pc_before = bus.InstrAddr;
    do_redirect(32'h80);
    chk("oor_addrerr", 32'(AddrErr), 32'h1);
    chk("oor_halted", 32'(Halted), 32'h1);
    chk("oor_pc", bus.InstrAddr, pc_before);
    do_redirect(32'h0);
    tick();
    chk("oor_resume_valid", 32'(bus.InstrValid), 32'h1);
    chk("oor_resume_addrerr", 32'(AddrErr), 32'h1);

    // Randomized traffic: ready jitter and occasional legal/illegal redirects.
    for (int c = 0; c < 1500; c++) begin
      bus.InstrReady = ($urandom_range(9) < 7);
      if ($urandom_range(31) == 0) begin
        r = $urandom_range(7);
        if (r == 0)      do_redirect({$urandom_range(31), 2'b00} | 32'($urandom_range(3, 1)));
        else if (r == 1) do_redirect(32'(MEM_SIZE) + 32'($urandom_range(255) * 4));
        else             do_redirect(32'($urandom_range(31) * 4));
      end else begin
        tick();
      end
    end

    bus.InstrReady = 1'b1;
    do_redirect(32'd100);
    for (int i = 0; i < 100 && !(Halted && !bus.InstrValid); i++) tick();
    chk("final_halted", 32'(Halted), 32'h1);
    chk("final_drained", 32'(bus.InstrValid), 32'h0);
    chk("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
